// File: rtl/prm_path_reader_pkg.sv
// Shared types and widths for the PRM path reader.
package prm_pkg;
  localparam int POSE_IDX_W = 11;
  localparam int POSE_CNT_W = 8;
  localparam int COORD_W    = 32;

  typedef enum logic [2:0] {IDLE, LOAD, FETCH, WAIT_RD, ISSUE, MOVE, DONE, ERR} state_t;

  // Sign-extend before subtracting so +/-2^31 extremes cannot wrap.
  function automatic logic signed [COORD_W:0] axis_diff(input logic [COORD_W-1:0] pos,
                                                        input logic [COORD_W-1:0] aim);
    return $signed({pos[COORD_W-1], pos}) - $signed({aim[COORD_W-1], aim});
  endfunction
endpackage

// File: rtl/prm_path_reader_if.sv
// Path-in / pose-RAM / stepper-target bundle of the PRM path reader.
interface prm_path_reader_if
  import prm_pkg::*;
#(parameter int STEPPERS_NUM = 6);
  logic                                 path_start;
  logic                                 abort;
  logic [POSE_CNT_W-1:0]                poseNum;
  logic [POSE_IDX_W-1:0]                poseIndex;
  logic                                 poseIndex_valid;
  logic                                 poseIndex_ready;
  logic                                 pose_rd_en;
  logic [POSE_IDX_W-1:0]                pose_rd_addr;
  logic [STEPPERS_NUM-1:0][COORD_W-1:0] pose_rd_data;
  logic [STEPPERS_NUM-1:0][COORD_W-1:0] stepperPosition;
  logic [STEPPERS_NUM-1:0][COORD_W-1:0] AimPosition;
  logic                                 aim_valid;
  logic                                 aim_ready;
  logic                                 busy;
  logic                                 done;
  logic                                 error;

  modport slave (
    input  path_start, abort, poseNum, poseIndex, poseIndex_valid, pose_rd_data,
           stepperPosition, aim_ready,
    output poseIndex_ready, pose_rd_en, pose_rd_addr, AimPosition, aim_valid, busy, done, error
  );
  modport master (
    output path_start, abort, poseNum, poseIndex, poseIndex_valid, pose_rd_data,
           stepperPosition, aim_ready,
    input  poseIndex_ready, pose_rd_en, pose_rd_addr, AimPosition, aim_valid, busy, done, error
  );
endinterface

// File: rtl/prm_path_reader_lifo.sv
// Path index stack: register array, synchronous write, asynchronous read.
module prm_pose_lifo #(
  parameter  int DEPTH = 256,
  parameter  int W     = 11,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] wr_ptr,
  input  logic [W-1:0]     wdata,
  input  logic [PTR_W-1:0] rd_ptr,
  output logic [W-1:0]     rdata
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[wr_ptr] <= wdata;

  assign rdata = mem[rd_ptr];
endmodule

// File: rtl/prm_path_reader.sv
// PRM path reader: buffers a goal-first index stream, replays it start-to-goal as stepper targets.
// Optional macro PRM_ARRIVE_TOL_EN: per-axis arrival within ARRIVE_TOL instead of exact match.
module prm_path_reader
  import prm_pkg::*;
#(
  parameter int STEPPERS_NUM = 6,
  parameter int POSE_COUNT   = 2048,
  parameter int PATH_DEPTH   = 256,
  parameter int ARRIVE_TOL   = 4
) (
  input logic              CLK,
  input logic              RST_n,
  prm_path_reader_if.slave bus
);
  localparam int PTR_W = $clog2(PATH_DEPTH);
  localparam logic [POSE_IDX_W:0] IDX_LIM = (POSE_IDX_W+1)'(POSE_COUNT);

  if (PATH_DEPTH < 255) begin : g_chk_depth
    $error("PATH_DEPTH must hold a full 255-pose path");
  end
  if (ARRIVE_TOL < 0) begin : g_chk_tol
    $error("ARRIVE_TOL must be non-negative");
  end

  state_t                               state, nxt;
  logic [PTR_W-1:0]                     wr_ptr, rd_ptr;
  logic [POSE_CNT_W-1:0]                count;
  logic [STEPPERS_NUM-1:0][COORD_W-1:0] aim;
  logic                                 zero_done;
  logic [POSE_IDX_W-1:0]                lifo_q;
  logic                                 accept, bad_idx, last_idx, arrived;
  logic [STEPPERS_NUM-1:0]              axis_ok;

  assign accept   = (state == LOAD) && bus.poseIndex_valid;
  assign bad_idx  = {1'b0, bus.poseIndex} >= IDX_LIM;
  assign last_idx = wr_ptr == (PTR_W'(count) - 1'b1);

  prm_pose_lifo #(.DEPTH(PATH_DEPTH), .W(POSE_IDX_W)) u_lifo (
    .clk    (CLK),
    .we     (accept && !bad_idx && !bus.abort),
    .wr_ptr (wr_ptr),
    .wdata  (bus.poseIndex),
    .rd_ptr (rd_ptr),
    .rdata  (lifo_q)
  );

  for (genvar a = 0; a < STEPPERS_NUM; a++) begin : g_axis
    logic signed [COORD_W:0] diff;
    assign diff = axis_diff(bus.stepperPosition[a], aim[a]);
`ifdef PRM_ARRIVE_TOL_EN
    logic [COORD_W:0] mag;
    assign mag        = diff[COORD_W] ? (COORD_W+1)'(-diff) : diff;
    assign axis_ok[a] = mag <= (COORD_W+1)'(ARRIVE_TOL);
`else
    assign axis_ok[a] = diff == '0;
`endif
  end
  assign arrived = &axis_ok;

  always_ff @(posedge CLK)
    if (!RST_n) state <= IDLE;
    else        state <= nxt;

  always_comb begin
    nxt = state;
    if (bus.abort) nxt = IDLE;
    else begin
      unique case (state)
        IDLE:    if (bus.path_start && bus.poseNum != '0) nxt = LOAD;
        LOAD:    if (accept) nxt = bad_idx ? ERR : (last_idx ? FETCH : LOAD);
        FETCH:   nxt = WAIT_RD;
        WAIT_RD: nxt = ISSUE;
        ISSUE:   if (bus.aim_ready) nxt = MOVE;
        MOVE:    if (arrived) nxt = (rd_ptr == '0) ? DONE : FETCH;
        DONE:    nxt = IDLE;
        ERR:     nxt = ERR;
        default: nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.poseIndex_ready = state == LOAD;
    bus.pose_rd_en      = state == FETCH;
    bus.pose_rd_addr    = (state == FETCH) ? lifo_q : '0;
    bus.aim_valid       = state == ISSUE;
    bus.busy            = state != IDLE;
    bus.done            = (state == DONE) || zero_done;
    bus.error           = state == ERR;
    bus.AimPosition     = aim;
  end

  // Pointers, length and target register; the target survives abort.
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      aim       <= '0;
      zero_done <= 1'b0;
    end else begin
      zero_done <= 1'b0;
      if (bus.abort) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        unique case (state)
          IDLE: if (bus.path_start) begin
            if (bus.poseNum == '0) zero_done <= 1'b1;
            else begin
              count  <= bus.poseNum;
              wr_ptr <= '0;
            end
          end
          LOAD: if (accept && !bad_idx) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (last_idx) rd_ptr <= PTR_W'(count) - 1'b1;
          end
          WAIT_RD: aim <= bus.pose_rd_data;
          MOVE:    if (arrived && rd_ptr != '0) rd_ptr <= rd_ptr - 1'b1;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_prm_path_reader.sv
// Directed self-checking bench for prm_path_reader with a pose RAM and stepper model.
module tb_prm_path_reader;
  localparam int N  = 6;
  // poseIndex is 11 bits, so an out-of-range index is only reachable with a smaller roadmap.
  localparam int PC = 2000;
  typedef logic [N-1:0][31:0] pose_t;

  logic  CLK = 1'b0;
  logic  RST_n = 1'b0;
  int    compared = 0, mismatched = 0;
  int    aim_hs = 0, done_cnt = 0, settle = 0;
  logic  auto_mode = 1'b1;
  pose_t manual_pos = '0;
  logic [10:0] rd_log[$];

  always #5 CLK = ~CLK;

  prm_path_reader_if #(.STEPPERS_NUM(N)) bus();

  prm_path_reader #(.STEPPERS_NUM(N), .POSE_COUNT(PC), .PATH_DEPTH(256), .ARRIVE_TOL(4)) dut (
    .CLK(CLK), .RST_n(RST_n), .bus(bus)
  );

  function automatic pose_t pose_of(input logic [10:0] addr);
    pose_t p;
    for (int a = 0; a < N; a++) begin
      if (addr == 11'd10)      p[a] = 32'd1000;
      else if (addr == 11'd11) p[a] = 32'h8000_0000;
      else                     p[a] = 32'(addr) * 100 + 32'(a);
    end
    return p;
  endfunction

  // Pose RAM (1-cycle latency), stepper model and event counters.
  always @(posedge CLK) begin
    if (!RST_n) begin
      bus.pose_rd_data    <= '0;
      bus.stepperPosition <= '0;
    end else begin
      if (bus.pose_rd_en) begin
        bus.pose_rd_data <= pose_of(bus.pose_rd_addr);
        rd_log.push_back(bus.pose_rd_addr);
      end
      if (bus.aim_valid && bus.aim_ready) aim_hs <= aim_hs + 1;
      if (bus.done) done_cnt <= done_cnt + 1;
      if (auto_mode) begin
        if (bus.aim_valid && bus.aim_ready) settle <= 10;
        else if (settle > 0) begin
          settle <= settle - 1;
          if (settle == 1) bus.stepperPosition <= bus.AimPosition;
        end
      end else bus.stepperPosition <= manual_pos;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic test_reset();
    RST_n = 1'b0;
    repeat (3) @(negedge CLK);
    compared++;
    if ({bus.busy, bus.done, bus.error, bus.aim_valid, bus.poseIndex_ready, bus.pose_rd_en} !== 6'b0) begin
      mismatched++;
      $display("FAIL reset_flags got=%b exp=000000", {bus.busy, bus.done, bus.error, bus.aim_valid,
               bus.poseIndex_ready, bus.pose_rd_en});
    end
    compared++;
    if (bus.pose_rd_addr !== 11'd0) begin
      mismatched++; $display("FAIL reset_addr got=%0h exp=0", bus.pose_rd_addr);
    end
    compared++;
    if (bus.AimPosition !== pose_t'(0)) begin
      mismatched++; $display("FAIL reset_aim got=%0h exp=0", bus.AimPosition);
    end
    RST_n = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_path3();
    int hs0 = aim_hs, d0 = done_cnt, r0 = rd_log.size(), n;
    logic [10:0] idx [3] = '{11'd5, 11'd9, 11'd12};
    logic [10:0] exp_rd [3] = '{11'd12, 11'd9, 11'd5};
    auto_mode = 1'b1; bus.aim_ready = 1'b1;
    bus.poseNum = 8'd3; bus.path_start = 1'b1;
    @(negedge CLK);
    bus.path_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.poseIndex = idx[i]; bus.poseIndex_valid = 1'b1;
      compared++;
      if (bus.poseIndex_ready !== 1'b1) begin
        mismatched++; $display("FAIL load_ready[%0d] got=%b exp=1", i, bus.poseIndex_ready);
      end
      @(negedge CLK);
    end
    bus.poseIndex_valid = 1'b0;
    compared++;
    if (bus.poseIndex_ready !== 1'b0) begin
      mismatched++; $display("FAIL ready_drop got=%b exp=0", bus.poseIndex_ready);
    end
    @(negedge CLK);
    compared++;
    if (bus.aim_valid !== 1'b0) begin
      mismatched++; $display("FAIL aim_early got=%b exp=0", bus.aim_valid);
    end
    @(negedge CLK);
    compared++;
    if (bus.aim_valid !== 1'b1 || bus.AimPosition !== pose_of(11'd12)) begin
      mismatched++;
      $display("FAIL first_aim got=%b/%0h exp=1/%0h", bus.aim_valid, bus.AimPosition, pose_of(11'd12));
    end
    for (n = 0; n < 300 && bus.done !== 1'b1; n++) @(negedge CLK);
    compared++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b1) begin
      mismatched++; $display("FAIL path3_done got=%b/%b exp=1/1", bus.done, bus.busy);
    end
    @(negedge CLK);
    compared++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      mismatched++; $display("FAIL path3_idle got=%b/%b exp=0/0", bus.busy, bus.done);
    end
    compared++;
    if (aim_hs - hs0 !== 3 || done_cnt - d0 !== 1) begin
      mismatched++; $display("FAIL path3_counts got=%0d/%0d exp=3/1", aim_hs - hs0, done_cnt - d0);
    end
    compared++;
    if (rd_log.size() - r0 !== 3) begin
      mismatched++; $display("FAIL path3_nreads got=%0d exp=3", rd_log.size() - r0);
    end else
      for (int i = 0; i < 3; i++) begin
        compared++;
        if (rd_log[r0+i] !== exp_rd[i]) begin
          mismatched++; $display("FAIL path3_read[%0d] got=%0d exp=%0d", i, rd_log[r0+i], exp_rd[i]);
        end
      end
    compared++;
    if (bus.AimPosition !== pose_of(11'd5)) begin
      mismatched++; $display("FAIL path3_last_aim got=%0h exp=%0h", bus.AimPosition, pose_of(11'd5));
    end
  endtask

  task automatic test_zero();
    int d0 = done_cnt, r0 = rd_log.size();
    bus.poseNum = 8'd0; bus.path_start = 1'b1;
    @(negedge CLK);
    bus.path_start = 1'b0;
    compared++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      mismatched++; $display("FAIL zero_done got=%b/%b exp=1/0", bus.done, bus.busy);
    end
    @(negedge CLK);
    compared++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      mismatched++; $display("FAIL zero_after got=%b/%b exp=0/0", bus.done, bus.busy);
    end
    compared++;
    if (rd_log.size() !== r0 || done_cnt - d0 !== 1) begin
      mismatched++; $display("FAIL zero_counts got=%0d/%0d exp=0/1", rd_log.size() - r0, done_cnt - d0);
    end
  endtask

  task automatic test_error();
    bus.poseNum = 8'd3; bus.path_start = 1'b1;
    @(negedge CLK);
    bus.path_start = 1'b0;
    bus.poseIndex = 11'(PC - 1); bus.poseIndex_valid = 1'b1;
    @(negedge CLK);
    compared++;
    if (bus.error !== 1'b0 || bus.poseIndex_ready !== 1'b1) begin
      mismatched++; $display("FAIL max_idx_ok got=%b/%b exp=0/1", bus.error, bus.poseIndex_ready);
    end
    bus.poseIndex = 11'(PC);
    @(negedge CLK);
    bus.poseIndex_valid = 1'b0;
    compared++;
    if ({bus.error, bus.poseIndex_ready, bus.busy} !== 3'b101) begin
      mismatched++; $display("FAIL err_enter got=%b exp=101", {bus.error, bus.poseIndex_ready, bus.busy});
    end
    repeat (5) @(negedge CLK);
    compared++;
    if (bus.error !== 1'b1) begin
      mismatched++; $display("FAIL err_sticky got=%b exp=1", bus.error);
    end
    bus.abort = 1'b1;
    @(negedge CLK);
    bus.abort = 1'b0;
    compared++;
    if (bus.error !== 1'b0 || bus.busy !== 1'b0) begin
      mismatched++; $display("FAIL err_abort got=%b/%b exp=0/0", bus.error, bus.busy);
    end
  endtask

  task automatic test_stall();
    pose_t exp = pose_of(11'd20);
    int low = 0, chg = 0, n;
    auto_mode = 1'b0; manual_pos = '0; bus.aim_ready = 1'b0;
    bus.poseNum = 8'd1; bus.path_start = 1'b1;
    @(negedge CLK);
    bus.path_start = 1'b0; bus.poseIndex = 11'd20; bus.poseIndex_valid = 1'b1;
    @(negedge CLK);
    bus.poseIndex_valid = 1'b0;
    for (n = 0; n < 10 && bus.aim_valid !== 1'b1; n++) @(negedge CLK);
    for (int i = 0; i < 20; i++) begin
      if (bus.aim_valid !== 1'b1) low++;
      if (bus.AimPosition !== exp) chg++;
      @(negedge CLK);
    end
    compared++;
    if (low !== 0) begin
      mismatched++; $display("FAIL stall_valid got=%0d low cycles exp=0", low);
    end
    compared++;
    if (chg !== 0) begin
      mismatched++; $display("FAIL stall_aim got=%0d wrong cycles exp=0", chg);
    end
    bus.aim_ready = 1'b1;
    @(negedge CLK);
    compared++;
    if (bus.aim_valid !== 1'b0) begin
      mismatched++; $display("FAIL stall_release got=%b exp=0", bus.aim_valid);
    end
    manual_pos = exp;
    for (n = 0; n < 20 && bus.done !== 1'b1; n++) @(negedge CLK);
    compared++;
    if (bus.done !== 1'b1) begin
      mismatched++; $display("FAIL stall_done got=%b exp=1", bus.done);
    end
    @(negedge CLK);
  endtask

  task automatic issue_one(input logic [10:0] idx);
    int n;
    bus.poseNum = 8'd1; bus.path_start = 1'b1;
    @(negedge CLK);
    bus.path_start = 1'b0; bus.poseIndex = idx; bus.poseIndex_valid = 1'b1;
    @(negedge CLK);
    bus.poseIndex_valid = 1'b0;
    for (n = 0; n < 10 && bus.aim_valid !== 1'b1; n++) @(negedge CLK);
    @(negedge CLK);
  endtask

  task automatic test_tol();
    logic seen = 1'b0, exp_seen;
    int n;
`ifdef PRM_ARRIVE_TOL_EN
    exp_seen = 1'b1;
`else
    exp_seen = 1'b0;
`endif
    auto_mode = 1'b0; bus.aim_ready = 1'b1;
    for (int a = 0; a < N; a++) manual_pos[a] = 32'd997;
    issue_one(11'd10);
    repeat (5) begin
      if (bus.done === 1'b1) seen = 1'b1;
      @(negedge CLK);
    end
    compared++;
    if (seen !== exp_seen) begin
      mismatched++; $display("FAIL tol_997 got=%b exp=%b", seen, exp_seen);
    end
    for (int a = 0; a < N; a++) manual_pos[a] = 32'd1000;
    for (n = 0; n < 10 && bus.busy === 1'b1; n++) @(negedge CLK);
    compared++;
    if (bus.busy !== 1'b0) begin
      mismatched++; $display("FAIL tol_exact got=%b exp=0", bus.busy);
    end
    // Target -2^31 against position 2^31-1: a 32-bit difference would wrap to -1.
    for (int a = 0; a < N; a++) manual_pos[a] = 32'h7fff_ffff;
    seen = 1'b0;
    issue_one(11'd11);
    repeat (5) begin
      if (bus.done === 1'b1) seen = 1'b1;
      @(negedge CLK);
    end
    compared++;
    if (seen !== 1'b0 || bus.busy !== 1'b1) begin
      mismatched++; $display("FAIL extreme_arrive got=%b/%b exp=0/1", seen, bus.busy);
    end
    bus.abort = 1'b1;
    @(negedge CLK);
    bus.abort = 1'b0;
    compared++;
    if (bus.busy !== 1'b0) begin
      mismatched++; $display("FAIL extreme_abort got=%b exp=0", bus.busy);
    end
  endtask

  task automatic test_abort();
    int n;
    auto_mode = 1'b0; manual_pos = '0; bus.aim_ready = 1'b1;
    bus.poseNum = 8'd2; bus.path_start = 1'b1;
    @(negedge CLK);
    bus.path_start = 1'b0; bus.poseIndex_valid = 1'b1;
    bus.poseIndex = 11'd3;
    @(negedge CLK);
    bus.poseIndex = 11'd4;
    @(negedge CLK);
    bus.poseIndex_valid = 1'b0;
    for (n = 0; n < 10 && bus.aim_valid !== 1'b1; n++) @(negedge CLK);
    @(negedge CLK);
    compared++;
    if (bus.busy !== 1'b1 || bus.aim_valid !== 1'b0) begin
      mismatched++; $display("FAIL abort_in_move got=%b/%b exp=1/0", bus.busy, bus.aim_valid);
    end
    bus.abort = 1'b1;
    @(negedge CLK);
    bus.abort = 1'b0;
    compared++;
    if (bus.busy !== 1'b0 || bus.AimPosition !== pose_of(11'd4)) begin
      mismatched++; $display("FAIL abort_idle got=%b/%0h exp=0/%0h", bus.busy, bus.AimPosition, pose_of(11'd4));
    end
    manual_pos = pose_of(11'd6);
    issue_one(11'd6);
    for (n = 0; n < 20 && bus.done !== 1'b1; n++) @(negedge CLK);
    compared++;
    if (bus.done !== 1'b1 || bus.AimPosition !== pose_of(11'd6) || rd_log[$] !== 11'd6) begin
      mismatched++;
      $display("FAIL abort_rerun got=%b/%0h/%0d exp=1/%0h/6", bus.done, bus.AimPosition, rd_log[$], pose_of(11'd6));
    end
    @(negedge CLK);
  endtask

  initial begin
    bus.path_start = 1'b0; bus.abort = 1'b0; bus.poseNum = '0;
    bus.poseIndex = '0; bus.poseIndex_valid = 1'b0; bus.aim_ready = 1'b0;
    test_reset();
    test_path3();
    test_zero();
    test_error();
    test_stall();
    test_tol();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
